// File: rtl/regfile_arb_pkg.sv
// Shared widths, types and helpers for the register-file read arbiter.
package regfile_arb_pkg;

    localparam int unsigned NREQ      = 4;
    localparam int unsigned REQ_IDX_W = 2;
    localparam int unsigned RADDR_W   = 4;
    localparam int unsigned DATA_W    = 32;

    typedef logic [REQ_IDX_W-1:0] req_idx_t;
    typedef logic [RADDR_W-1:0]   raddr_t;
    typedef logic [DATA_W-1:0]    data_t;

    // Extract the register address presented by requester i.
    function automatic raddr_t addr_of(input logic [NREQ*RADDR_W-1:0] addr_bus,
                                       input req_idx_t                i);
        return addr_bus[i*RADDR_W +: RADDR_W];
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after rr wins.
module rr_priority_picker
    import regfile_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  req_idx_t        rr,
    output logic [NREQ-1:0] gnt,
    output req_idx_t        win,
    output logic            any
);

    // Search rr, rr+1, rr+2, rr+3 (wrapping) and take the first active request.
    always_comb begin
        req_idx_t idx;
        gnt = '0;
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = rr + req_idx_t'(k);
            if (!any && req[idx]) begin
                any      = 1'b1;
                win      = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter for four readers sharing one external 16:1 register
// read mux; two-edge latency from acceptance to registered read data.
module regfile_read_arbiter
    import regfile_arb_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*RADDR_W-1:0] addr,
    input  logic                    stall,
    output logic [NREQ-1:0]         gnt,
    output raddr_t                  mux_sel,
    input  data_t                   mux_y,
    output logic                    rd_valid,
    output req_idx_t                rd_id,
    output data_t                   rd_data
);

    req_idx_t        rr;
    logic [NREQ-1:0] pick_gnt;
    req_idx_t        pick_win;
    logic            pick_any;
    logic            accept;
    logic            inflight;
    req_idx_t        inflight_id;

    rr_priority_picker u_picker (
        .req (req),
        .rr  (rr),
        .gnt (pick_gnt),
        .win (pick_win),
        .any (pick_any)
    );

    // Grant is suppressed during reset and stall; any grant is an acceptance
    // because the picker only selects requesters whose req bit is high.
    always_comb begin
        gnt    = '0;
        accept = 1'b0;
        if (reset_n && !stall && pick_any) begin
            gnt    = pick_gnt;
            accept = 1'b1;
        end
    end

    // Acceptance loads mux_sel and the rotation pointer; the following edge
    // captures the mux output for the in-flight read.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr          <= '0;
            mux_sel     <= '0;
            inflight    <= 1'b0;
            inflight_id <= '0;
            rd_valid    <= 1'b0;
            rd_id       <= '0;
            rd_data     <= '0;
        end else begin
            if (accept) begin
                rr          <= pick_win + req_idx_t'(1);
                mux_sel     <= addr_of(addr, pick_win);
                inflight_id <= pick_win;
            end
            inflight <= accept;
            rd_valid <= inflight;
            if (inflight) begin
                rd_data <= mux_y;
                rd_id   <= inflight_id;
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all compared against a behavioural model every cycle.
module tb_regfile_read_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [15:0] addr;
    logic        stall;
    logic [3:0]  gnt;
    logic [3:0]  mux_sel;
    logic [31:0] mux_y;
    logic        rd_valid;
    logic [1:0]  rd_id;
    logic [31:0] rd_data;

    logic [31:0] regs [16];

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    int          m_rr;
    logic [3:0]  m_sel;
    bit          m_pend;
    int          m_pend_id;
    logic        m_rd_valid;
    logic [1:0]  m_rd_id;
    logic [31:0] m_rd_data;

    // Samples from the most recent cycle
    logic [3:0]  s_gnt;
    logic [3:0]  s_sel;
    logic        s_valid;
    logic [1:0]  s_id;
    logic [31:0] s_data;

    always #5 clk = ~clk;

    assign mux_y = regs[mux_sel];

    regfile_read_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .addr     (addr),
        .stall    (stall),
        .gnt      (gnt),
        .mux_sel  (mux_sel),
        .mux_y    (mux_y),
        .rd_valid (rd_valid),
        .rd_id    (rd_id),
        .rd_data  (rd_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Index of the winning requester, or -1 when nothing may be granted.
    function automatic int m_winner(input logic [3:0] r, input int rr, input logic st,
                                    input logic rst_n);
        if (!rst_n || st) return -1;
        for (int k = 0; k < 4; k++)
            if (r[(rr + k) % 4]) return (rr + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_rr       = 0;
        m_sel      = 4'h0;
        m_pend     = 0;
        m_pend_id  = 0;
        m_rd_valid = 1'b0;
        m_rd_id    = 2'd0;
        m_rd_data  = 32'h0;
    endtask

    // One clock cycle: drive inputs, compare DUT against the model, then
    // advance the model across the rising edge.
    task automatic cycle(input logic [3:0] r, input logic [15:0] a, input logic st,
                         input logic rst_n);
        int          w;
        logic [3:0]  exp_gnt;
        @(negedge clk);
        req     = r;
        addr    = a;
        stall   = st;
        reset_n = rst_n;
        #1;
        w       = m_winner(r, m_rr, st, rst_n);
        exp_gnt = (w < 0) ? 4'b0000 : 4'(1 << w);
        s_gnt   = gnt;
        s_sel   = mux_sel;
        s_valid = rd_valid;
        s_id    = rd_id;
        s_data  = rd_data;
        chk("gnt",      32'(s_gnt),   32'(exp_gnt));
        chk("mux_sel",  32'(s_sel),   32'(m_sel));
        chk("rd_valid", 32'(s_valid), 32'(m_rd_valid));
        chk("rd_id",    32'(s_id),    32'(m_rd_id));
        chk("rd_data",  s_data,       m_rd_data);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_rd_valid = m_pend;
            if (m_pend) begin
                m_rd_data = regs[m_sel];
                m_rd_id   = 2'(m_pend_id);
            end
            m_pend = (w >= 0);
            if (w >= 0) begin
                m_pend_id = w;
                m_sel     = a[w*4 +: 4];
                m_rr      = (w + 1) % 4;
            end
        end
    endtask

    task automatic do_reset();
        cycle(4'b0000, 16'h0000, 1'b0, 1'b0);
        cycle(4'b0000, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] exp_g [5];
        logic [1:0] exp_i [5];
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        regs[11] = 32'hDEAD_000B;
        reset_n = 1'b0;
        req     = '0;
        addr    = '0;
        stall   = 1'b0;
        model_reset();

        // Reset state
        do_reset();
        cycle(4'b0000, 16'h0000, 1'b0, 1'b1);
        chk("rst_mux_sel",  32'(s_sel),   32'h0);
        chk("rst_rd_valid", 32'(s_valid), 32'h0);
        chk("rst_rd_data",  s_data,       32'h0);

        // Full request rotation
        do_reset();
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 7; i++) begin
            cycle(4'b1111, 16'h3210, 1'b0, 1'b1);
            if (i < 5) chk("rot_gnt", 32'(s_gnt), 32'(exp_g[i]));
            if (i >= 2) begin
                chk("rot_valid", 32'(s_valid), 32'h1);
                chk("rot_id",    32'(s_id),    32'(exp_i[i-2]));
            end
        end

        // Single read from requester 2 at address B
        do_reset();
        cycle(4'b0100, 16'h0B00, 1'b0, 1'b1);
        chk("r2_gnt", 32'(s_gnt), 32'h4);
        cycle(4'b0000, 16'h0B00, 1'b0, 1'b1);
        chk("r2_sel", 32'(s_sel), 32'hB);
        cycle(4'b0000, 16'h0000, 1'b0, 1'b1);
        chk("r2_valid", 32'(s_valid), 32'h1);
        chk("r2_data",  s_data,       32'hDEAD_000B);
        chk("r2_id",    32'(s_id),    32'h2);
        cycle(4'b0000, 16'h0000, 1'b0, 1'b1);
        chk("r2_valid_off", 32'(s_valid), 32'h0);
        chk("r2_data_hold", s_data,       32'hDEAD_000B);

        // Stall blocks grants; rr still 0 afterwards
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0101, 16'h1234, 1'b1, 1'b1);
            chk("stall_gnt",   32'(s_gnt),   32'h0);
            chk("stall_valid", 32'(s_valid), 32'h0);
        end
        cycle(4'b0101, 16'h1234, 1'b0, 1'b1);
        chk("unstall_gnt", 32'(s_gnt), 32'h1);

        // Stall right after acceptance does not cancel the read
        do_reset();
        cycle(4'b0010, 16'h0070, 1'b0, 1'b1);
        chk("sa_gnt", 32'(s_gnt), 32'h2);
        cycle(4'b1111, 16'h0070, 1'b1, 1'b1);
        chk("sa_gnt_stalled", 32'(s_gnt), 32'h0);
        cycle(4'b1111, 16'h0070, 1'b1, 1'b1);
        chk("sa_gnt_stalled2", 32'(s_gnt),   32'h0);
        chk("sa_valid",        32'(s_valid), 32'h1);
        chk("sa_id",           32'(s_id),    32'h1);
        chk("sa_data",         s_data,       regs[7]);

        // Reset immediately after acceptance discards the read
        do_reset();
        cycle(4'b0010, 16'h00C0, 1'b0, 1'b1);
        cycle(4'b0000, 16'h0000, 1'b0, 1'b0);
        cycle(4'b0000, 16'h0000, 1'b0, 1'b1);
        chk("ra_valid", 32'(s_valid), 32'h0);
        chk("ra_sel",   32'(s_sel),   32'h0);
        cycle(4'b1111, 16'h0000, 1'b0, 1'b1);
        chk("ra_valid2", 32'(s_valid), 32'h0);
        chk("ra_rr0",    32'(s_gnt),   32'h1);

        // Two requesters on the same address are not merged
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(4'b1001, 16'h5005, 1'b0, 1'b1);
            chk("same_gnt", 32'(s_gnt), (i % 2 == 0) ? 32'h1 : 32'h8);
            if (i >= 2) begin
                chk("same_valid", 32'(s_valid), 32'h1);
                chk("same_data",  s_data,       regs[5]);
                chk("same_id",    32'(s_id),    (i == 2) ? 32'h0 : 32'h3);
            end
        end

        // Randomized traffic with occasional stall and reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle(4'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 60) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_read_arbiter.md
REGFILE_READ_ARBITER -- requirements
Module: regfile_read_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named clk and reset_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 req  input  4  per-requester read request; bit i = requester i; held high until granted.
REQ-005 addr  input  16  packed register addresses; addr[4i+3:4i] = address for requester i.
REQ-006 stall  input  1  when high, no new grant is issued.
REQ-007 gnt  output  4  combinational one-hot grant; all-zero when nothing is granted.
REQ-008 mux_sel  output  4  registered select driving the shared 16:1 32-bit register read mux.
REQ-009 mux_y  input  32  data returned by that mux for the current mux_sel.
REQ-010 rd_valid  output  1  registered; high for exactly one cycle per accepted request.
REQ-011 rd_id  output  2  requester index owning rd_data; valid while rd_valid is high.
REQ-012 rd_data  output  32  registered read data; valid while rd_valid is high.

Function
REQ-013 A request SHALL be accepted on a rising clk edge where req[i] and gnt[i] are both high; the requester drops or changes req[i] after that edge.
REQ-014 gnt SHALL be one-hot or zero, SHALL be zero when stall=1 or req=0, and SHALL never select a requester whose req bit is low.
REQ-015 Arbitration SHALL be round-robin over a 2-bit pointer rr; search order is rr, rr+1, rr+2, rr+3 (mod 4), and the first requester found with req high wins.
REQ-016 On acceptance of requester w, rr SHALL update to (w+1) mod 4; with no acceptance, rr SHALL hold.
REQ-017 On acceptance, mux_sel SHALL load addr of the winner at the same edge; with no acceptance, mux_sel SHALL hold its last value.
REQ-018 The cycle after acceptance, the block SHALL capture mux_y into rd_data, set rd_valid=1, and set rd_id=w at the next edge (acceptance edge E0 -> data valid after E1; latency 2 edges).
REQ-019 Throughput SHALL be one accepted request per cycle, back-to-back with no bubble, including consecutive grants to different requesters for the same address.
REQ-020 Requests for identical addresses SHALL NOT be merged; each acceptance produces its own rd_valid pulse.
REQ-021 Asserting stall SHALL NOT cancel a read already accepted; that read still completes with rd_valid one edge later.
REQ-022 When no read is in flight, rd_valid SHALL be 0 and rd_data/rd_id SHALL hold their previous values.
REQ-023 A requester continuously requesting SHALL be granted within 4 accepted cycles; starvation is impossible.

Reset
REQ-024 While reset_n=0 at an edge, the block SHALL set rr=0, mux_sel=4'h0, rd_valid=0, rd_id=0, rd_data=32'h0, and clear the in-flight flag.
REQ-025 gnt SHALL be forced to 0 while reset_n is low.
REQ-026 A read accepted at the edge before reset asserts SHALL be discarded, with no rd_valid pulse after reset.

Structure
REQ-027 The shared package regfile_arb_pkg SHALL hold NREQ=4, REQ_IDX_W=2, RADDR_W=4, and DATA_W=32.
REQ-028 Round-robin selection SHALL live in one combinational sub-module, rr_priority_picker, with inputs req[3:0] and rr[1:0] and outputs gnt[3:0], win[1:0], and any.
REQ-029 The block SHALL NOT instantiate the 16:1 mux; it connects externally through mux_sel and mux_y.

Verification
REQ-030 Reset then req=4'b1111 held, stall=0 -> gnt sequence 0001, 0010, 0100, 1000, 0001, with rd_id 0,1,2,3,0 on consecutive cycles two edges later.
REQ-031 req[2] only, addr2=4'hB, mux model returns 32'hDEAD_000B for sel B -> mux_sel=B after E0, rd_valid=1 with rd_data=32'hDEAD_000B and rd_id=2 after E1, then rd_valid=0.
REQ-032 stall=1 with req=4'b0101 for 3 cycles -> gnt=0 and rd_valid=0 throughout; after stall drops, gnt=0001 first (rr=0).
REQ-033 Stall asserted in the cycle right after acceptance of requester 1 -> rd_valid pulse for id 1 still appears, and no new grant occurs during stall.
REQ-034 Reset asserted at the edge immediately after acceptance -> no rd_valid pulse; rr=0 and mux_sel=0 after reset.
REQ-035 Requesters 0 and 3 both on addr 4'h5 continuously -> alternating grants, two rd_valid pulses with identical rd_data, no merging.
